// File: rtl/one_cold_rr_arbiter_pkg.sv
// Shared types and the rotate-priority search used by the one-cold arbiter
// family (and the planned one-hot variant).
package one_cold_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam int MAX_WIDTH = 32;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;

    // First active-low request above ptr (modulo width), skipping excluded bits.
    // An X request bit makes the if-condition unknown, so it is simply passed over.
    function automatic pick_t rr_pick(input logic [MAX_WIDTH-1:0] req_n,
                                      input idx_t                 ptr,
                                      input logic [MAX_WIDTH-1:0] exclude,
                                      input int                   width);
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 1; i <= MAX_WIDTH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= width) cand = cand - width;
            if (i <= width && !res.found && !req_n[cand[IDX_W-1:0]] && !exclude[cand[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/one_cold_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface one_cold_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic                     enable;
    logic [WIDTH-1:0]         req_n;
    logic                     done;
    logic [WIDTH-1:0]         grant_n;
    logic                     grant_valid;
    logic [$clog2(WIDTH)-1:0] grant_idx;
    logic [7:0]               hold_cnt;

    modport master (output enable, req_n, done,
                    input  grant_n, grant_valid, grant_idx, hold_cnt);

    modport slave  (input  enable, req_n, done,
                    output grant_n, grant_valid, grant_idx, hold_cnt);
endinterface

// File: rtl/one_cold_rr_arbiter_pick.sv
// Combinational rotate-priority finder: pads the request/exclude vectors to
// the package maximum and narrows the chosen index back to this width.
module one_cold_rr_pick
    import one_cold_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req_n,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    input  logic [WIDTH-1:0]         exclude,
    output logic                     found,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int IW = $clog2(WIDTH);

    logic [MAX_WIDTH-1:0] req_ext;
    logic [MAX_WIDTH-1:0] excl_ext;
    pick_t                res;

    always_comb begin
        req_ext                = '1;
        req_ext[WIDTH-1:0]     = req_n;
        excl_ext               = '0;
        excl_ext[WIDTH-1:0]    = exclude;
        res                    = rr_pick(req_ext, idx_t'(ptr), excl_ext, WIDTH);
        found                  = res.found;
        idx                    = IW'(res.idx);
    end
endmodule

// File: rtl/one_cold_rr_arbiter.sv
// Round-robin arbiter driving an active-low one-cold grant vector; all
// outputs are registered so the vector is only ever all-ones or one-cold.
module one_cold_rr_arbiter
    import one_cold_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    one_cold_rr_arbiter_if.slave  bus
);
    localparam int IW        = $clog2(WIDTH);
    localparam bit HANDOFF   = (GAP_CYCLES == 0);
    // The IDLE cycle is itself the last all-ones cycle, so GAP only covers the rest.
    localparam bit USE_GAP   = (GAP_CYCLES > 1);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [2:0]       gap_cnt;

    logic             in_grant;
    logic [IW-1:0]    pick_ptr;
    logic [WIDTH-1:0] pick_excl;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             keep;

    always_comb begin
        in_grant  = (state == GRANT);
        pick_ptr  = in_grant ? bus.grant_idx : ptr;
        pick_excl = in_grant ? (WIDTH'(1) << bus.grant_idx) : '0;
        keep      = bus.enable && !bus.done && !bus.req_n[bus.grant_idx]
                    && (bus.hold_cnt != 8'(MAX_HOLD));
    end

    one_cold_rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req_n   (bus.req_n),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= IW'(WIDTH - 1);
            gap_cnt         <= '0;
            bus.grant_n     <= '1;
            bus.grant_valid <= 1'b0;
            bus.grant_idx   <= '0;
            bus.hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.hold_cnt <= '0;
                    if (bus.enable && pick_found) begin
                        state           <= GRANT;
                        bus.grant_n     <= ~(WIDTH'(1) << pick_idx);
                        bus.grant_valid <= 1'b1;
                        bus.grant_idx   <= pick_idx;
                        bus.hold_cnt    <= 8'd1;
                    end
                end
                GRANT: begin
                    if (keep) begin
                        if (bus.hold_cnt != 8'hFF) bus.hold_cnt <= bus.hold_cnt + 8'd1;
                    end else begin
                        ptr <= bus.grant_idx;
                        if (HANDOFF && bus.enable && pick_found) begin
                            bus.grant_n   <= ~(WIDTH'(1) << pick_idx);
                            bus.grant_idx <= pick_idx;
                            bus.hold_cnt  <= 8'd1;
                        end else begin
                            bus.grant_n     <= '1;
                            bus.grant_valid <= 1'b0;
                            bus.hold_cnt    <= '0;
                            if (USE_GAP) begin
                                state   <= GAP;
                                gap_cnt <= 3'd1;
                            end else begin
                                state   <= IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    bus.hold_cnt <= '0;
                    if (gap_cnt >= 3'(GAP_CYCLES - 1)) state <= IDLE;
                    else                               gap_cnt <= gap_cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_one_cold_rr_arbiter.sv
// Directed bench: WIDTH=4, MAX_HOLD=4, GAP_CYCLES=1 (bus_a) plus a
// GAP_CYCLES=0 copy (bus_b) for the back-to-back handoff.
module tb_one_cold_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    one_cold_rr_arbiter_if #(.WIDTH(4)) bus_a ();
    one_cold_rr_arbiter_if #(.WIDTH(4)) bus_b ();

    one_cold_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4), .GAP_CYCLES(1)) u_dut_a (
        .clock (clk), .reset (rst), .bus (bus_a));

    one_cold_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4), .GAP_CYCLES(0)) u_dut_b (
        .clock (clk), .reset (rst), .bus (bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [3:0] gn, input logic gv,
                            input logic [1:0] gi, input logic [7:0] hc);
        check({tag, "_gn"}, 32'(bus_a.grant_n), 32'(gn));
        check({tag, "_gv"}, 32'(bus_a.grant_valid), 32'(gv));
        check({tag, "_gi"}, 32'(bus_a.grant_idx), 32'(gi));
        check({tag, "_hc"}, 32'(bus_a.hold_cnt), 32'(hc));
    endtask

    task automatic expect_b(input string tag, input logic [3:0] gn, input logic gv,
                            input logic [1:0] gi, input logic [7:0] hc);
        check({tag, "_gn"}, 32'(bus_b.grant_n), 32'(gn));
        check({tag, "_gv"}, 32'(bus_b.grant_valid), 32'(gv));
        check({tag, "_gi"}, 32'(bus_b.grant_idx), 32'(gi));
        check({tag, "_hc"}, 32'(bus_b.hold_cnt), 32'(hc));
    endtask

    function automatic logic one_cold_ok(input logic [3:0] g);
        return (g === 4'b1111) || (g === 4'b1110) || (g === 4'b1101)
            || (g === 4'b1011) || (g === 4'b0111);
    endfunction

    // One-cold watcher on both grant vectors, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onecold_a", 32'(one_cold_ok(bus_a.grant_n)), 32'd1);
            check("onecold_b", 32'(one_cold_ok(bus_b.grant_n)), 32'd1);
            check("valid_a", 32'(bus_a.grant_valid), 32'(bus_a.grant_n != 4'b1111));
            check("valid_b", 32'(bus_b.grant_valid), 32'(bus_b.grant_n != 4'b1111));
        end
    end

    initial begin
        bus_a.enable = 1'b1; bus_a.req_n = 4'b0000; bus_a.done = 1'b0;
        bus_b.enable = 1'b0; bus_b.req_n = 4'b1111; bus_b.done = 1'b0;

        // Reset held with every requester active: nothing may be granted.
        for (int i = 0; i < 5; i++) begin
            step();
            mon_en = 1'b1;
            expect_a("rst", 4'b1111, 1'b0, 2'd0, 8'd0);
        end
        expect_b("rst_b", 4'b1111, 1'b0, 2'd0, 8'd0);

        // Single requester 0, 1-cycle latency, voluntary release, one gap, re-grant.
        rst = 1'b0; bus_a.req_n = 4'b1110;
        step(); expect_a("first", 4'b1110, 1'b1, 2'd0, 8'd1);
        step(); expect_a("hold2", 4'b1110, 1'b1, 2'd0, 8'd2);
        bus_a.done = 1'b1;
        step(); expect_a("done_rel", 4'b1111, 1'b0, 2'd0, 8'd0);
        bus_a.done = 1'b0;
        step(); expect_a("regrant", 4'b1110, 1'b1, 2'd0, 8'd1);

        // All request: 4-cycle grants rotating 0,1,2,3 with one all-ones cycle between.
        bus_a.req_n = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) step();
            if (k % 5 < 4)
                expect_a($sformatf("rot%0d", k), ~(4'b0001 << ((k / 5) % 4)), 1'b1,
                         2'((k / 5) % 4), 8'((k % 5) + 1));
            else
                expect_a($sformatf("rot%0d", k), 4'b1111, 1'b0, 2'((k / 5) % 4), 8'd0);
        end

        // Owner 2, then enable drop: release, no new grant; re-enable gives idx 3.
        bus_a.req_n = 4'b1011;
        step(); expect_a("own2", 4'b1011, 1'b1, 2'd2, 8'd1);
        bus_a.enable = 1'b0;
        step(); expect_a("dis_rel", 4'b1111, 1'b0, 2'd2, 8'd0);
        bus_a.req_n = 4'b0000;
        step(); expect_a("dis_idle1", 4'b1111, 1'b0, 2'd2, 8'd0);
        step(); expect_a("dis_idle2", 4'b1111, 1'b0, 2'd2, 8'd0);
        bus_a.enable = 1'b1;
        step(); expect_a("reen", 4'b0111, 1'b1, 2'd3, 8'd1);

        // Owner drops its request, pointer at 3 makes idx 2 the next winner.
        bus_a.req_n = 4'b1011;
        step(); expect_a("req_drop", 4'b1111, 1'b0, 2'd3, 8'd0);
        step(); expect_a("own2b", 4'b1011, 1'b1, 2'd2, 8'd1);

        // Asynchronous reset mid-cycle clears the grant before the next edge.
        #2 rst = 1'b1;
        #1 expect_a("async_rst", 4'b1111, 1'b0, 2'd0, 8'd0);
        step(); expect_a("rst_hold", 4'b1111, 1'b0, 2'd0, 8'd0);
        rst = 1'b0; bus_a.req_n = 4'b0000; bus_a.done = 1'b1;
        step(); expect_a("post_rst", 4'b1110, 1'b1, 2'd0, 8'd1);
        bus_a.done = 1'b0;
        step(); expect_a("idle_done_ign", 4'b1110, 1'b1, 2'd0, 8'd2);

        // GAP_CYCLES=0: MAX_HOLD expiry hands 0 -> 1 -> 0 with no all-ones cycle.
        bus_b.enable = 1'b1; bus_b.req_n = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            step(); expect_b($sformatf("ho0_%0d", k), 4'b1110, 1'b1, 2'd0, 8'(k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            step(); expect_b($sformatf("ho1_%0d", k), 4'b1101, 1'b1, 2'd1, 8'(k + 1));
        end
        step(); expect_b("ho_back", 4'b1110, 1'b1, 2'd0, 8'd1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/one_cold_rr_arbiter.md
Name: one_cold_rr_arbiter

Overview:
- Round-robin arbiter that drives an active-low, one-cold grant vector for the bus the one-cold assertion monitor watches.
- It is the producer side of the one-cold interface. Requesters assert active-low req_n. The arbiter grants exactly one of them by pulling its grant_n bit low.
- Between owners the vector returns to all-ones, which is the inactive value.
- It sits upstream of the ovl_one_cold checkers in the alw test benches and is the legal-traffic source for them.

Parameters:
- WIDTH, 4: number of requesters and the grant_n width; legal range 2..32.
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant; legal range 1..255.
- GAP_CYCLES, 1: all-ones cycles inserted between two grants; legal range 0..7.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  arbitration enable; low forces release and blocks new grants
- req_n  in  WIDTH  active-low request per requester
- done  in  1  current owner releases the grant voluntarily
- grant_n  out  WIDTH  one-cold grant; all-ones when no owner
- grant_valid  out  1  high exactly when grant_n has one zero bit
- grant_idx  out  $clog2(WIDTH)  index of the zero bit; holds last owner while idle
- hold_cnt  out  8  cycles the current owner has held the grant, saturating

Behaviour:
- Reset (async assert): grant_n all ones, grant_valid 0, grant_idx 0, hold_cnt 0, state IDLE, priority pointer set to WIDTH-1 so requester 0 wins first.
- All outputs are registered. grant_n is never anything other than all-ones or exactly one zero, in every cycle including during reset release.
- State IDLE:
  - Moves to GRANT when enable=1 and any req_n bit is 0.
  - The winner is the first zero bit of req_n searching upward from pointer+1 modulo WIDTH.
  - grant_n updates on that same edge, so the request-to-grant latency is 1 clock.
- State GRANT:
  - hold_cnt increments each cycle, starting at 1 on the grant cycle.
  - Release occurs when any of the following is sampled: done=1, owner's req_n=1, enable=0, or hold_cnt==MAX_HOLD.
  - On release, grant_n goes all ones on the next edge and the pointer is loaded with the owner index.
  - The state then moves to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - With GAP_CYCLES=0 and a pending request, the arbiter may move directly GRANT->GRANT to the new winner on one edge.
    - The vector changes one-cold to one-cold with no intermediate all-ones cycle.
    - The old owner is excluded from that pick.
    - hold_cnt reloads to 1.
- State GAP:
  - grant_n stays all ones for GAP_CYCLES cycles using a 3-bit counter, then the state returns to IDLE.
  - Requests are evaluated in IDLE, not in GAP.
- Simultaneous done and MAX_HOLD expiry count as a single release.
- done asserted while not in GRANT is ignored.
- A sole requester gets a new grant after the gap and its hold count restarts. Starvation-freedom comes from the pointer.
- Requests changing during GAP are sampled only in IDLE.
- enable=0 in any state leads to IDLE or GAP on the next edge with all-ones output. The pointer is retained.
- Reset asserted mid-grant drops grant_n to all ones immediately (async). The pointer returns to WIDTH-1.
- hold_cnt saturates at 255 and clears to 0 in IDLE and GAP.
- req_n containing X is treated as no request for the affected bits. This never propagates X to grant_n.

Decomposition:
- Package one_cold_pkg:
  - state enum {IDLE, GRANT, GAP}
  - localparam type for the index width
  - function rr_pick(req_n, ptr, exclude), returning the found flag and the index
- Sub-module one_cold_rr_pick: purely combinational rotate-priority finder wrapping rr_pick. It is reused by the future one-hot variant.
- Top level contains the FSM, the counters and the output registers.

Test Plan (WIDTH=4, MAX_HOLD=4, GAP_CYCLES=1, with ovl_one_cold bound to grant_n):
- Reset held 5 clocks with req_n=4'b0000 -> grant_n=4'b1111, grant_valid=0 throughout; ovl checker silent.
- Release reset, req_n=4'b1110 -> one clock later grant_n=4'b1110, grant_idx=0, hold_cnt=1; done pulse at hold_cnt=2 -> next edge grant_n=4'b1111, one gap cycle, then re-grant 4'b1110.
- req_n=4'b0000 held for 40 clocks -> grants rotate through idx 0,1,2,3,0. Each lasts exactly 4 cycles, separated by one 4'b1111 cycle. No checker fire.
- Owner idx 2 granted, then enable deasserted -> next edge grant_n=4'b1111 and no new grant. Re-enable with req_n=4'b0000 -> idx 3 wins.
- Assert reset asynchronously mid-cycle while grant_n=4'b1011 -> grant_n=4'b1111 before the next clock edge. After release with req_n=4'b0000, idx 0 wins.
- Rebuild with GAP_CYCLES=0, req_n=4'b1100, MAX_HOLD expiry -> grant_n goes 4'b1110 to 4'b1101 on one edge with no all-ones cycle. The checker reports no error, and in no cycle does grant_n have more than one zero bit.
